// File: rtl/tpu_tile_scheduler_if.sv
// Host/TPU-side handshake bundle for the tile scheduler.
// slave modport is the scheduler's view, master is the host/TPU side.
interface tpu_tile_scheduler_if #(
    parameter int A_BITS = 15,
    parameter int B_BITS = 15
);
    logic              start;
    logic [10:0]       k_in;
    logic [11:0]       m_in;
    logic [8:0]        n_in;
    logic              busy;
    logic              done;
    logic              tpu_in_valid;
    logic [10:0]       tpu_k;
    logic [11:0]       tpu_m;
    logic [8:0]        tpu_n;
    logic              tpu_busy;
    logic [A_BITS-1:0] a_base;
    logic [B_BITS-1:0] b_base;
    logic              tile_ready;
    logic [11:0]       tile_m0;
    logic [8:0]        tile_n0;
    logic              drain_ack;
    logic [15:0]       tile_cnt;

    modport slave (
        input  start, k_in, m_in, n_in, tpu_busy, drain_ack,
        output busy, done, tpu_in_valid, tpu_k, tpu_m, tpu_n,
               a_base, b_base, tile_ready, tile_m0, tile_n0, tile_cnt
    );

    modport master (
        output start, k_in, m_in, n_in, tpu_busy, drain_ack,
        input  busy, done, tpu_in_valid, tpu_k, tpu_m, tpu_n,
               a_base, b_base, tile_ready, tile_m0, tile_n0, tile_cnt
    );
endinterface

// File: rtl/tpu_tile_scheduler.sv
// Tile scheduler: splits a KxMxN GEMM job into TILE_MxTILE_N launches of the
// TPU, N outer / M inner, and holds after each tile until the host drains C.
// Optional macro TILE_SCHED_PERF_EN adds perf_compute / perf_stall counters.
module tpu_tile_scheduler #(
    parameter int TILE_M = 64,
    parameter int TILE_N = 64,
    parameter int A_BITS = 15,
    parameter int B_BITS = 15
) (
    input  logic clk,
    input  logic reset,
    tpu_tile_scheduler_if.slave bus
`ifdef TILE_SCHED_PERF_EN
    ,
    output logic [31:0] perf_compute,
    output logic [31:0] perf_stall
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_GUARD, S_WAIT, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    logic [10:0]       r_k, r_tk;
    logic [11:0]       r_m, r_m0, r_tm, r_tm0;
    logic [8:0]        r_n, r_n0, r_tn, r_tn0;
    logic [A_BITS-1:0] r_ab;
    logic [B_BITS-1:0] r_bb;
    logic [15:0]       r_cnt;
    logic              r_busy, r_done, r_iv, r_rdy, r_zero;

    logic [12:0] w_m0_adv;
    logic [9:0]  w_n0_adv;
    logic        w_more_m, w_more_n, w_zero;
    logic [11:0] w_rem_m;
    logic [8:0]  w_rem_n;

    // next-tile origin candidates and remaining extents
    assign w_m0_adv = {1'b0, r_m0} + 13'(TILE_M);
    assign w_n0_adv = {1'b0, r_n0} + 10'(TILE_N);
    assign w_more_m = w_m0_adv < {1'b0, r_m};
    assign w_more_n = w_n0_adv < {1'b0, r_n};
    assign w_rem_m  = r_m - w_m0_adv[11:0];
    assign w_rem_n  = r_n - w_n0_adv[8:0];
    assign w_zero   = (bus.k_in == '0) || (bus.m_in == '0) || (bus.n_in == '0);

    function automatic logic [11:0] clip_m(input logic [11:0] v);
        return (v > 12'(TILE_M)) ? 12'(TILE_M) : v;
    endfunction

    function automatic logic [8:0] clip_n(input logic [8:0] v);
        return (v > 9'(TILE_N)) ? 9'(TILE_N) : v;
    endfunction

    // main sequencer; every output is a register updated with the state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_k <= '0;  r_tk <= '0;
            r_m <= '0;  r_m0 <= '0; r_tm <= '0; r_tm0 <= '0;
            r_n <= '0;  r_n0 <= '0; r_tn <= '0; r_tn0 <= '0;
            r_ab <= '0; r_bb <= '0; r_cnt <= '0;
            r_busy <= 1'b0; r_done <= 1'b0; r_iv <= 1'b0;
            r_rdy <= 1'b0;  r_zero <= 1'b0;
        end else begin
            r_iv   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_k <= bus.k_in; r_m <= bus.m_in; r_n <= bus.n_in;
                    r_m0 <= '0; r_n0 <= '0; r_ab <= '0; r_bb <= '0; r_cnt <= '0;
                    r_busy <= 1'b1;
                    if (w_zero) begin
                        // zero-sized job: spend one extra DONE cycle so done
                        // lands two cycles after start with busy high for both
                        r_zero  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tk    <= bus.k_in;
                        r_tm    <= clip_m(bus.m_in);
                        r_tn    <= clip_n(bus.n_in);
                        r_iv    <= 1'b1;
                        r_state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: r_state <= S_GUARD;
                // TPU busy is not yet valid right after the launch pulse
                S_GUARD:  r_state <= S_WAIT;
                S_WAIT: if (!bus.tpu_busy) begin
                    r_cnt   <= r_cnt + 16'd1;
                    r_rdy   <= 1'b1;
                    r_tm0   <= r_m0;
                    r_tn0   <= r_n0;
                    r_state <= S_DRAIN;
                end
                S_DRAIN: if (bus.drain_ack) begin
                    r_rdy <= 1'b0;
                    if (w_more_m) begin
                        r_m0    <= w_m0_adv[11:0];
                        r_ab    <= r_ab + A_BITS'(27'(r_k) * 27'(TILE_M / 4));
                        r_tm    <= clip_m(w_rem_m);
                        r_iv    <= 1'b1;
                        r_state <= S_LAUNCH;
                    end else if (w_more_n) begin
                        r_m0    <= '0;
                        r_ab    <= '0;
                        r_n0    <= w_n0_adv[8:0];
                        r_bb    <= r_bb + B_BITS'(27'(r_k) * 27'(TILE_N / 4));
                        r_tm    <= clip_m(r_m);
                        r_tn    <= clip_n(w_rem_n);
                        r_iv    <= 1'b1;
                        r_state <= S_LAUNCH;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: if (r_zero) begin
                    r_zero <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef TILE_SCHED_PERF_EN
    logic [31:0] r_pc, r_ps;

    // saturating cycle counters: compute (GUARD+WAIT) and drain stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
            r_ps <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_pc <= '0;
            r_ps <= '0;
        end else begin
            if ((r_state == S_GUARD || r_state == S_WAIT) && r_pc != '1) r_pc <= r_pc + 32'd1;
            if (r_state == S_DRAIN && r_ps != '1) r_ps <= r_ps + 32'd1;
        end
    end

    assign perf_compute = r_pc;
    assign perf_stall   = r_ps;
`endif

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.tpu_in_valid = r_iv;
    assign bus.tpu_k        = r_tk;
    assign bus.tpu_m        = r_tm;
    assign bus.tpu_n        = r_tn;
    assign bus.a_base       = r_ab;
    assign bus.b_base       = r_bb;
    assign bus.tile_ready   = r_rdy;
    assign bus.tile_m0      = r_tm0;
    assign bus.tile_n0      = r_tn0;
    assign bus.tile_cnt     = r_cnt;
endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Directed bench for tpu_tile_scheduler: job table with hand-computed launch
// records, plus sequences for zero dims, drain backpressure and mid-job reset.
module tb_tpu_tile_scheduler;
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tpu_tile_scheduler_if #(.A_BITS(15), .B_BITS(15)) bus ();

`ifdef TILE_SCHED_PERF_EN
    logic [31:0] perf_compute, perf_stall;
`endif

    tpu_tile_scheduler #(.TILE_M(64), .TILE_N(64), .A_BITS(15), .B_BITS(15)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef TILE_SCHED_PERF_EN
        ,
        .perf_compute(perf_compute),
        .perf_stall(perf_stall)
`endif
    );

    // TPU model: busy rises one cycle after the launch is sampled and stays
    // high for busy_len cycles
    int busy_len;
    int tpu_cd;
    initial tpu_cd = 0;
    always @(posedge clk) begin
        if (bus.tpu_in_valid) tpu_cd <= busy_len + 1;
        else if (tpu_cd != 0) tpu_cd <= tpu_cd - 1;
    end
    assign bus.tpu_busy = (tpu_cd != 0) && (tpu_cd <= busy_len);

    typedef struct {
        int k, m, n, blen, dly, nl, li, pc, ps;
    } job_t;
    typedef struct {
        int tm, tn, ab, bb;
    } lrec_t;

    job_t  jobs[7];
    lrec_t lt[17];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs_nonzero();
        int c = 0;
        if (bus.busy !== 1'b0) c++;
        if (bus.done !== 1'b0) c++;
        if (bus.tpu_in_valid !== 1'b0) c++;
        if (bus.tile_ready !== 1'b0) c++;
        if (bus.tpu_k !== '0) c++;
        if (bus.tpu_m !== '0) c++;
        if (bus.tpu_n !== '0) c++;
        if (bus.a_base !== '0) c++;
        if (bus.b_base !== '0) c++;
        if (bus.tile_m0 !== '0) c++;
        if (bus.tile_n0 !== '0) c++;
        if (bus.tile_cnt !== '0) c++;
        return c;
    endfunction

    // run one table job to completion, draining each tile after jobs[j].dly cycles
    task automatic run_job(input int j);
        int nl = 0, age = 0, cyc = 0, idx;
        bit got_done = 0;
        logic first_iv;
        lrec_t got[8];
        int gk[8];
        busy_len = jobs[j].blen;
        bus.k_in = 11'(jobs[j].k);
        bus.m_in = 12'(jobs[j].m);
        bus.n_in = 9'(jobs[j].n);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        first_iv = bus.tpu_in_valid;
        while (!got_done && cyc < 3000) begin
            if (bus.tpu_in_valid) begin
                if (nl < 8) begin
                    got[nl] = '{int'(bus.tpu_m), int'(bus.tpu_n), int'(bus.a_base), int'(bus.b_base)};
                    gk[nl] = int'(bus.tpu_k);
                end
                nl++;
            end
            if (bus.done) begin
                got_done = 1;
                chk($sformatf("job%0d_tile_cnt", j), bus.tile_cnt, jobs[j].nl);
            end
            bus.drain_ack = 1'b0;
            if (bus.tile_ready) begin
                age++;
                if (age == jobs[j].dly + 1) bus.drain_ack = 1'b1;
            end else age = 0;
            if (!got_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.drain_ack = 1'b0;
        chk($sformatf("job%0d_done_seen", j), got_done, 1);
        chk($sformatf("job%0d_launch_at_t1", j), first_iv, (jobs[j].nl > 0) ? 1 : 0);
        chk($sformatf("job%0d_launches", j), nl, jobs[j].nl);
        for (int i = 0; i < nl && i < jobs[j].nl && i < 8; i++) begin
            idx = jobs[j].li + i;
            chk($sformatf("job%0d_l%0d_tpu_m", j, i), got[i].tm, lt[idx].tm);
            chk($sformatf("job%0d_l%0d_tpu_n", j, i), got[i].tn, lt[idx].tn);
            chk($sformatf("job%0d_l%0d_a_base", j, i), got[i].ab, lt[idx].ab);
            chk($sformatf("job%0d_l%0d_b_base", j, i), got[i].bb, lt[idx].bb);
            chk($sformatf("job%0d_l%0d_tpu_k", j, i), gk[i], jobs[j].k);
        end
        @(negedge clk);
        chk($sformatf("job%0d_idle_after_done", j), {bus.busy, bus.done}, 0);
`ifdef TILE_SCHED_PERF_EN
        if (jobs[j].pc >= 0) begin
            chk($sformatf("job%0d_perf_compute", j), perf_compute, jobs[j].pc);
            chk($sformatf("job%0d_perf_stall", j), perf_stall, jobs[j].ps);
        end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, bad, nl;

        //        k     m    n  blen dly nl  li   pc  ps
        jobs[0] = '{16,   64,  64, 20, 3, 1, 0,  22, 4};
        jobs[1] = '{8,    130, 70, 6,  1, 6, 1,  -1, -1};
        jobs[2] = '{4,    8,   200, 3, 0, 4, 7,  -1, -1};
        jobs[3] = '{2047, 192, 4,  2,  2, 3, 11, -1, -1};
        jobs[4] = '{1,    65,  1,  0,  0, 2, 14, -1, -1};
        jobs[5] = '{0,    5,   5,  0,  0, 0, 0,  -1, -1};
        jobs[6] = '{4,    4,   4,  10, 5, 1, 16, 12, 6};
        //        tpu_m tpu_n a_base b_base
        lt[0]  = '{64, 64, 0,     0};
        lt[1]  = '{64, 64, 0,     0};
        lt[2]  = '{64, 64, 128,   0};
        lt[3]  = '{2,  64, 256,   0};
        lt[4]  = '{64, 6,  0,     128};
        lt[5]  = '{64, 6,  128,   128};
        lt[6]  = '{2,  6,  256,   128};
        lt[7]  = '{8,  64, 0,     0};
        lt[8]  = '{8,  64, 0,     64};
        lt[9]  = '{8,  64, 0,     128};
        lt[10] = '{8,  8,  0,     192};
        lt[11] = '{64, 4,  0,     0};
        lt[12] = '{64, 4,  32752, 0};
        lt[13] = '{64, 4,  32736, 0};
        lt[14] = '{64, 1,  0,     0};
        lt[15] = '{1,  1,  16,    0};
        lt[16] = '{4,  4,  0,     0};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.k_in = '0;
        bus.m_in = '0;
        bus.n_in = '0;
        bus.drain_ack = 1'b0;
        busy_len = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs_nonzero(), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_outputs", outs_nonzero(), 0);

        for (int j = 0; j < 7; j++) run_job(j);

        // zero M: done two cycles after start, busy for exactly those two
        bus.k_in = 11'd4; bus.m_in = 12'd0; bus.n_in = 9'd4;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("zero_c1_busy_done_iv", {bus.busy, bus.done, bus.tpu_in_valid}, 3'b100);
        @(negedge clk);
        chk("zero_c2_busy_done_iv", {bus.busy, bus.done, bus.tpu_in_valid}, 3'b110);
        chk("zero_tile_cnt", bus.tile_cnt, 0);
        @(negedge clk);
        chk("zero_c3_busy_done_iv", {bus.busy, bus.done, bus.tpu_in_valid}, 3'b000);

        // drain backpressure with a stray ack during WAIT
        busy_len = 20;
        bus.k_in = 11'd4; bus.m_in = 12'd128; bus.n_in = 9'd4;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.drain_ack = 1'b1;
        @(negedge clk);
        bus.drain_ack = 1'b0;
        chk("bp_stray_ack_ready_busy", {bus.tile_ready, bus.busy}, 2'b01);
        cyc = 0;
        while (!bus.tile_ready && cyc < 100) begin @(negedge clk); cyc++; end
        chk("bp_ready_seen", bus.tile_ready, 1);
        chk("bp_tile_cnt", bus.tile_cnt, 1);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!bus.tile_ready || bus.tpu_in_valid || bus.done || !bus.busy ||
                bus.tile_m0 != 0 || bus.tile_n0 != 0) bad++;
        end
        chk("bp_hold_bad_cycles", bad, 0);
        bus.drain_ack = 1'b1;
        @(negedge clk);
        bus.drain_ack = 1'b0;
        chk("bp_release_ready_iv", {bus.tile_ready, bus.tpu_in_valid}, 2'b01);
        chk("bp_tile2_a_base", bus.a_base, 64);
        cyc = 0;
        while (!bus.tile_ready && cyc < 100) begin @(negedge clk); cyc++; end
        chk("bp_tile2_m0", bus.tile_m0, 64);
        bus.drain_ack = 1'b1;
        @(negedge clk);
        bus.drain_ack = 1'b0;
        chk("bp_done_after_ack", {bus.done, bus.tile_ready}, 2'b10);
        chk("bp_final_tile_cnt", bus.tile_cnt, 2);
        @(negedge clk);

        // reset during WAIT of the second tile of a 3-tile job
        busy_len = 15;
        bus.k_in = 11'd4; bus.m_in = 12'd192; bus.n_in = 9'd4;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nl = 0;
        cyc = 0;
        while (nl < 2 && cyc < 200) begin
            bus.drain_ack = bus.tile_ready;
            if (bus.tpu_in_valid) nl++;
            if (nl < 2) begin @(negedge clk); cyc++; end
        end
        bus.drain_ack = 1'b0;
        chk("rst_tile2_a_base", bus.a_base, 64);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_outputs_cleared", outs_nonzero(), 0);
        reset = 1'b0;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done || bus.tpu_in_valid || bus.busy) bad++;
        end
        chk("rst_no_done_or_launch", bad, 0);
        run_job(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
